// File: rtl/ps2_host_tx_if.sv
// PS/2 host transmitter CPU-side request bundle.
// Command byte handshake plus completion/error status pulses.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       done;
  logic       err_noack;
  logic       err_timeout;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, busy, done,
    input  err_noack, err_timeout
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, busy, done,
    output err_noack, err_timeout
  );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send,
// 8 data bits LSB first, odd parity, stop, device ack.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES   = 5000,
  parameter int TIMEOUT_CYCLES   = 750000,
  parameter int IDLE_WAIT_CYCLES = 2500
) (
  input  logic clk,
  input  logic rstn,
  input  logic ps2_clk_in,
  input  logic ps2_data_in,
  output logic ps2_clk_oe,
  output logic ps2_data_oe,
  ps2_host_tx_if.slave cpu
);

  localparam int CMAX =
    (INHIBIT_CYCLES > IDLE_WAIT_CYCLES) ?
    INHIBIT_CYCLES : IDLE_WAIT_CYCLES;
  localparam int CW = $clog2(CMAX + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [CW-1:0] INH_PRE  =
    CW'(INHIBIT_CYCLES - 2);
  localparam logic [CW-1:0] INH_LAST =
    CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] IDL_LAST =
    CW'(IDLE_WAIT_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST =
    TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_SHIFT,
    S_ACK,
    S_WAIT
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [TW-1:0] tmo, tmo_n;
  logic [3:0]    k, k_n;
  logic [8:0]    sh, sh_n;
  logic          clk_oe_n, data_oe_n;
  logic          ready_q, ready_n;
  logic          busy_q, busy_n;
  logic          done_q, done_n;
  logic          nack_q, nack_n;
  logic          terr_q, terr_n;
  logic          c_s1, c_s2, c_h;
  logic          d_s1, d_s2;
  logic          fall, tmo_hit;

  assign fall    = c_h & ~c_s2;
  assign tmo_hit = (tmo == TMO_LAST);

  assign cpu.tx_ready    = ready_q;
  assign cpu.busy        = busy_q;
  assign cpu.done        = done_q;
  assign cpu.err_noack   = nack_q;
  assign cpu.err_timeout = terr_q;

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    tmo_n     = tmo;
    k_n       = k;
    sh_n      = sh;
    clk_oe_n  = ps2_clk_oe;
    data_oe_n = ps2_data_oe;
    ready_n   = ready_q;
    busy_n    = busy_q;
    done_n    = 1'b0;
    nack_n    = 1'b0;
    terr_n    = 1'b0;
    unique case (state)
      S_IDLE: begin
        ready_n   = 1'b1;
        busy_n    = 1'b0;
        clk_oe_n  = 1'b0;
        data_oe_n = 1'b0;
        if (cpu.tx_valid && ready_q) begin
          state_n  = S_INHIBIT;
          sh_n     = {~^cpu.tx_data, cpu.tx_data};
          cnt_n    = '0;
          clk_oe_n = 1'b1;
          ready_n  = 1'b0;
          busy_n   = 1'b1;
        end
      end
      S_INHIBIT: begin
        cnt_n = cnt + 1'b1;
        if (cnt == INH_PRE) data_oe_n = 1'b1;
        if (cnt == INH_LAST) begin
          state_n   = S_SHIFT;
          clk_oe_n  = 1'b0;
          data_oe_n = 1'b1;
          tmo_n     = '0;
          k_n       = '0;
        end
      end
      S_SHIFT, S_ACK, S_WAIT: begin
        tmo_n = tmo + 1'b1;
        // timeout outranks a coincident clock fall
        if (tmo_hit) begin
          state_n   = S_IDLE;
          clk_oe_n  = 1'b0;
          data_oe_n = 1'b0;
          terr_n    = 1'b1;
          busy_n    = 1'b0;
        end else if (state == S_SHIFT) begin
          if (fall) begin
            k_n = k + 4'd1;
            if (k == 4'd9) begin
              data_oe_n = 1'b0;
              state_n   = S_ACK;
            end else begin
              data_oe_n = ~sh[0];
              sh_n      = {1'b0, sh[8:1]};
            end
          end
        end else if (state == S_ACK) begin
          if (fall) begin
            if (!d_s2) begin
              state_n = S_WAIT;
              cnt_n   = '0;
            end else begin
              state_n = S_IDLE;
              nack_n  = 1'b1;
              busy_n  = 1'b0;
            end
          end
        end else begin
          if (c_s2 && d_s2) begin
            if (cnt == IDL_LAST) begin
              state_n = S_IDLE;
              done_n  = 1'b1;
              busy_n  = 1'b0;
            end else begin
              cnt_n = cnt + 1'b1;
            end
          end else begin
            cnt_n = '0;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= S_IDLE;
      cnt         <= '0;
      tmo         <= '0;
      k           <= '0;
      sh          <= '0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      nack_q      <= 1'b0;
      terr_q      <= 1'b0;
      c_s1        <= 1'b1;
      c_s2        <= 1'b1;
      c_h         <= 1'b1;
      d_s1        <= 1'b1;
      d_s2        <= 1'b1;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      tmo         <= tmo_n;
      k           <= k_n;
      sh          <= sh_n;
      ps2_clk_oe  <= clk_oe_n;
      ps2_data_oe <= data_oe_n;
      ready_q     <= ready_n;
      busy_q      <= busy_n;
      done_q      <= done_n;
      nack_q      <= nack_n;
      terr_q      <= terr_n;
      c_s1        <= ps2_clk_in;
      c_s2        <= c_s1;
      c_h         <= c_s2;
      d_s1        <= ps2_data_in;
      d_s2        <= d_s1;
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain
// PS/2 device model on the wired-AND lines.
module tb_ps2_host_tx;

  localparam int INH = 50;
  localparam int TMO = 3000;
  localparam int IDW = 20;
  localparam int H   = 20;

  logic clk;
  logic rstn;
  logic dev_clk;
  logic dev_data;
  logic ps2_clk_in;
  logic ps2_data_in;
  logic ps2_clk_oe;
  logic ps2_data_oe;

  int checks;
  int errors;
  int n_done, n_nack, n_tmo;
  int b_done, b_nack, b_tmo;
  logic [1:0] last_oe;

  ps2_host_tx_if bus ();

  ps2_host_tx #(
    .INHIBIT_CYCLES  (INH),
    .TIMEOUT_CYCLES  (TMO),
    .IDLE_WAIT_CYCLES(IDW)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .ps2_clk_in (ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .cpu        (bus)
  );

  assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
  assign ps2_data_in = dev_data & ~ps2_data_oe;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.done) n_done++;
    if (bus.err_noack) n_nack++;
    if (bus.err_timeout) n_tmo++;
    if (bus.done | bus.err_noack | bus.err_timeout)
      last_oe = {ps2_clk_oe, ps2_data_oe};
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    chk("send_ready", 32'(bus.tx_ready), 32'd1);
    b_done  = n_done;
    b_nack  = n_nack;
    b_tmo   = n_tmo;
    last_oe = 2'b11;
    bus.tx_data  = b;
    bus.tx_valid = 1'b1;
    @(negedge clk);
    bus.tx_valid = 1'b0;
  endtask

  task automatic inhibit_phase();
    int n;
    int len;
    logic first_doe;
    n = 0;
    while (!ps2_clk_oe && n < 100) begin
      @(negedge clk);
      n++;
    end
    first_doe = ps2_data_oe;
    len = 0;
    while (ps2_clk_oe && len < INH + 100) begin
      @(negedge clk);
      len++;
    end
    chk("inh_first_doe", 32'(first_doe), 32'd0);
    chk("inh_len", 32'(len), 32'(INH));
    chk("start_doe", 32'(ps2_data_oe), 32'd1);
  endtask

  // mode 0 ack, 1 no ack, 2 stray tx_valid, 3 reset
  task automatic dev_xfer(input logic [10:0] frame,
                          input int mode);
    logic [10:0] got;
    logic stop;
    got  = '0;
    stop = 1'b0;
    inhibit_phase();
    for (int k = 1; k <= 11 && !stop; k++) begin
      repeat (H) @(negedge clk);
      got[k-1] = ps2_data_in;
      if (k == 11 && mode != 1) dev_data = 1'b0;
      if (mode == 2 && k == 3) begin
        chk("stray_ready", 32'(bus.tx_ready), 32'd0);
        bus.tx_data  = 8'h00;
        bus.tx_valid = 1'b1;
      end
      repeat (2) @(negedge clk);
      bus.tx_valid = 1'b0;
      dev_clk = 1'b0;
      if (mode == 3 && k == 5) begin
        repeat (8) @(negedge clk);
        chk("pre_rst_doe", 32'(ps2_data_oe), 32'd1);
        #1 rstn = 1'b0;
        #1;
        chk("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
        chk("rst_data_oe", 32'(ps2_data_oe), 32'd0);
        dev_clk  = 1'b1;
        dev_data = 1'b1;
        stop = 1'b1;
      end else begin
        repeat (H) @(negedge clk);
        dev_clk = 1'b1;
      end
    end
    if (!stop) begin
      repeat (2) @(negedge clk);
      dev_data = 1'b1;
      chk("frame", 32'(got), 32'(frame));
    end
  endtask

  task automatic tmo_xfer();
    int n;
    inhibit_phase();
    n = 0;
    while (!bus.err_timeout && n < TMO + 10) begin
      @(negedge clk);
      n++;
    end
    chk("tmo_len", 32'(n), 32'(TMO));
  endtask

  task automatic end_xfer(input int ed,
                          input int en,
                          input int et);
    int n;
    n = 0;
    while (bus.busy && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("busy_drop", 32'(bus.busy), 32'd0);
    repeat (2) @(negedge clk);
    chk("n_done", 32'(n_done - b_done), 32'(ed));
    chk("n_nack", 32'(n_nack - b_nack), 32'(en));
    chk("n_tmo", 32'(n_tmo - b_tmo), 32'(et));
    chk("pulse_oe", 32'(last_oe), 32'd0);
    chk("end_ready", 32'(bus.tx_ready), 32'd1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    n_done = 0;
    n_nack = 0;
    n_tmo  = 0;
    b_done = 0;
    b_nack = 0;
    b_tmo  = 0;
    last_oe = 2'b00;
    rstn     = 1'b0;
    dev_clk  = 1'b1;
    dev_data = 1'b1;
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(bus.tx_ready), 32'd1);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_coe", 32'(ps2_clk_oe), 32'd0);
    chk("rst_doe", 32'(ps2_data_oe), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    rstn = 1'b1;
    repeat (5) @(negedge clk);

    send(8'hED);
    dev_xfer(11'b1_1_11101101_0, 0);
    end_xfer(1, 0, 0);

    send(8'hF4);
    dev_xfer(11'b1_0_11110100_0, 0);
    end_xfer(1, 0, 0);

    send(8'hED);
    dev_xfer(11'b1_1_11101101_0, 1);
    end_xfer(0, 1, 0);

    send(8'hF4);
    tmo_xfer();
    end_xfer(0, 0, 1);

    send(8'hED);
    dev_xfer(11'b1_1_11101101_0, 3);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(bus.tx_ready), 32'd1);
    chk("post_rst_busy", 32'(bus.busy), 32'd0);
    send(8'hFF);
    dev_xfer(11'b1_1_11111111_0, 0);
    end_xfer(1, 0, 0);

    send(8'hED);
    dev_xfer(11'b1_1_11101101_0, 2);
    end_xfer(1, 0, 0);
    repeat (50) @(negedge clk);
    chk("no_requeue_coe", 32'(ps2_clk_oe), 32'd0);
    chk("no_requeue_busy", 32'(bus.busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
